// File: rtl/writeback_arbiter_if.sv
// Writeback bundle: pipeline/multiplier/divider results in, register-file write port and hazard flags out.
// Latency: none, signal grouping only.
// Backpressure: done inputs are held until the matching ack; main results cannot be refused.
`ifndef WORD
`define WORD 64
`endif

interface writeback_arbiter_if #(
    parameter int WORD = `WORD
);
    logic            main_write;
    logic [4:0]      main_reg;
    logic            main_fp;
    logic [WORD-1:0] main_data;

    logic            multiplier_done;
    logic [4:0]      mult_reg;
    logic            mult_fp;
    logic [WORD-1:0] mult_data;
    logic            mult_ack;

    logic            divider_done;
    logic [4:0]      div_reg;
    logic            div_fp;
    logic [WORD-1:0] div_data;
    logic            div_ack;

    logic [4:0]      read_reg1;
    logic [4:0]      read_reg2;
    logic            read_fp;
    logic            pending_hit;
    logic            stall;

    logic            wb_write;
    logic [4:0]      wb_reg;
    logic            wb_fp;
    logic [WORD-1:0] wb_data;

    // Producer side: pipeline, execution units and decode.
    modport master (
        output main_write, main_reg, main_fp, main_data,
        output multiplier_done, mult_reg, mult_fp, mult_data,
        output divider_done, div_reg, div_fp, div_data,
        output read_reg1, read_reg2, read_fp,
        input  mult_ack, div_ack, pending_hit, stall,
        input  wb_write, wb_reg, wb_fp, wb_data
    );

    // Arbiter side.
    modport slave (
        input  main_write, main_reg, main_fp, main_data,
        input  multiplier_done, mult_reg, mult_fp, mult_data,
        input  divider_done, div_reg, div_fp, div_data,
        input  read_reg1, read_reg2, read_fp,
        output mult_ack, div_ack, pending_hit, stall,
        output wb_write, wb_reg, wb_fp, wb_data
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Merges main/multiplier/divider results onto one register-file write port; optional bypass under WB_BYPASS_EN.
// Latency: main 1 cycle, deferred results 2 cycles minimum (1 with WB_BYPASS_EN and an idle port).
// Backpressure: done inputs wait un-acked while the deferred FIFO is full; stall warns decode before it fills.
`ifndef WORD
`define WORD 64
`endif

module writeback_arbiter #(
    parameter int DEPTH = 4,
    parameter int WORD  = `WORD
) (
    input logic                write_clk,
    input logic                reset,
    writeback_arbiter_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [4:0]      rd;
        logic            fp;
        logic [WORD-1:0] dat;
    } ent_t;

    ent_t            mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;
    logic [CW-1:0]   free0;
    logic [CW-1:0]   free1;
    logic [CW-1:0]   n_enq;
    logic [DEPTH-1:0] ent_vld;

    ent_t main_ent;
    ent_t mult_ent;
    ent_t div_ent;
    ent_t wr_ent;

    logic pend;
    logic conflict_hit;
    logic main_xzr;
    logic mult_xzr;
    logic div_xzr;
    logic main_enq;
    logic main_direct;
    logic deq;
    logic byp_ok;
    logic mult_byp;
    logic div_byp;
    logic mult_need;
    logic div_need;
    logic mult_acc;
    logic div_acc;
    logic mult_enq;
    logic div_enq;
    logic wr_vld;

    logic            stall_q;
    logic            wb_write_q;
    logic [4:0]      wb_reg_q;
    logic            wb_fp_q;
    logic [WORD-1:0] wb_data_q;

    assign main_ent = {bus.main_reg, bus.main_fp, bus.main_data};
    assign mult_ent = {bus.mult_reg, bus.mult_fp, bus.mult_data};
    assign div_ent  = {bus.div_reg, bus.div_fp, bus.div_data};

    // XZR discard applies to the integer file only.
    assign main_xzr = !bus.main_fp && (bus.main_reg == 5'd31);
    assign mult_xzr = !bus.mult_fp && (bus.mult_reg == 5'd31);
    assign div_xzr  = !bus.div_fp && (bus.div_reg == 5'd31);

    always_comb begin
        ent_vld = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_vld[i] = ({1'b0, PW'(i) - rd_ptr}) < count;
        end
    end

    always_comb begin
        pend         = 1'b0;
        conflict_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i]) begin
                if (mem[i].fp == bus.read_fp &&
                    (mem[i].rd == bus.read_reg1 || mem[i].rd == bus.read_reg2)) begin
                    pend = 1'b1;
                end
                if (mem[i].fp == bus.main_fp && mem[i].rd == bus.main_reg) begin
                    conflict_hit = 1'b1;
                end
            end
        end
    end

    // A main write may not overtake an older queued write to the same register.
    assign main_enq    = bus.main_write && !main_xzr && conflict_hit;
    assign main_direct = bus.main_write && !main_xzr && !conflict_hit;
    assign deq         = (count != '0) && !main_direct;

`ifdef WB_BYPASS_EN
    assign byp_ok = !bus.main_write && (count == '0);
`else
    assign byp_ok = 1'b0;
`endif
    assign mult_byp = byp_ok && bus.multiplier_done && !mult_xzr;
    assign div_byp  = byp_ok && bus.divider_done && !div_xzr && !mult_byp;

    // Slots available after this cycle's dequeue and any deferred main write.
    assign free0 = CW'(DEPTH) - count + CW'(deq) - CW'(main_enq);

    assign mult_need = bus.multiplier_done && !mult_xzr && !mult_byp;
    assign mult_acc  = !reset && bus.multiplier_done && (!mult_need || free0 != '0);
    assign mult_enq  = mult_acc && mult_need;

    assign free1 = free0 - CW'(mult_enq);

    assign div_need = bus.divider_done && !div_xzr && !div_byp;
    assign div_acc  = !reset && bus.divider_done && (!div_need || free1 != '0);
    assign div_enq  = div_acc && div_need;

    assign n_enq     = CW'(main_enq) + CW'(mult_enq) + CW'(div_enq);
    assign count_nxt = count + n_enq - CW'(deq);

    always_comb begin
        wr_vld = 1'b0;
        wr_ent = '0;
        if (main_direct) begin
            wr_vld = 1'b1;
            wr_ent = main_ent;
        end else if (deq) begin
            wr_vld = 1'b1;
            wr_ent = mem[rd_ptr];
        end else if (mult_byp) begin
            wr_vld = 1'b1;
            wr_ent = mult_ent;
        end else if (div_byp) begin
            wr_vld = 1'b1;
            wr_ent = div_ent;
        end
    end

    // Arrival order within a cycle: deferred main, then multiplier, then divider.
    always_ff @(posedge write_clk) begin
        if (main_enq) begin
            mem[wr_ptr] <= main_ent;
        end
        if (mult_enq) begin
            mem[wr_ptr + PW'(main_enq)] <= mult_ent;
        end
        if (div_enq) begin
            mem[wr_ptr + PW'(main_enq) + PW'(mult_enq)] <= div_ent;
        end
    end

    always_ff @(posedge write_clk) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            stall_q    <= 1'b0;
            wb_write_q <= 1'b0;
            wb_reg_q   <= '0;
            wb_fp_q    <= 1'b0;
            wb_data_q  <= '0;
        end else begin
            rd_ptr     <= rd_ptr + PW'(deq);
            wr_ptr     <= wr_ptr + n_enq[PW-1:0];
            count      <= count_nxt;
            stall_q    <= count_nxt >= CW'(DEPTH - 1);
            wb_write_q <= wr_vld;
            if (wr_vld) begin
                wb_reg_q  <= wr_ent.rd;
                wb_fp_q   <= wr_ent.fp;
                wb_data_q <= wr_ent.dat;
            end
        end
    end

    assign bus.mult_ack    = mult_acc;
    assign bus.div_ack     = div_acc;
    assign bus.pending_hit = pend;
    assign bus.stall       = stall_q;
    assign bus.wb_write    = wb_write_q;
    assign bus.wb_reg      = wb_reg_q;
    assign bus.wb_fp       = wb_fp_q;
    assign bus.wb_data     = wb_data_q;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomized and directed stimulus against a queue-level writeback model; a monitor checks every register-file write.
module tb_writeback_arbiter;
    localparam int DEPTH = 4;
    localparam int WORD  = 64;

    typedef struct packed {
        logic [4:0]      r;
        logic            f;
        logic [WORD-1:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    writeback_arbiter_if #(.WORD(WORD)) bus ();

    writeback_arbiter #(.DEPTH(DEPTH), .WORD(WORD)) dut (
        .write_clk (clk),
        .reset     (reset),
        .bus       (bus)
    );

    ent_t mq[$];
    ent_t exp_q[$];
    ent_t mon_e;
    bit   m_stall;
    bit   exp_mack;
    bit   exp_dack;
    int   checks;
    int   errors;
    logic [WORD-1:0] rf_int [32];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit xz(input logic [4:0] r, input logic f);
        return !f && (r == 5'd31);
    endfunction

    function automatic logic [4:0] rnd_reg();
        if ($urandom_range(0, 5) == 0) return 5'd31;
        return 5'($urandom_range(0, 7));
    endfunction

    // Reference model: FIFO as a queue, one cycle of the arbitration rules per call.
    task automatic model_cycle();
        bit   pend, conflict, direct, deq, byp_ok, mbyp, dbyp, mneed, dneed, mack, dack;
        ent_t me, mu, dv;
        me = '{r: bus.main_reg, f: bus.main_fp, d: bus.main_data};
        mu = '{r: bus.mult_reg, f: bus.mult_fp, d: bus.mult_data};
        dv = '{r: bus.div_reg, f: bus.div_fp, d: bus.div_data};
        pend = 0;
        conflict = 0;
        mack = 0;
        dack = 0;
        foreach (mq[i]) begin
            if (mq[i].f == bus.read_fp && (mq[i].r == bus.read_reg1 || mq[i].r == bus.read_reg2)) pend = 1;
            if (bus.main_write && mq[i].f == bus.main_fp && mq[i].r == bus.main_reg) conflict = 1;
        end
        chk("pending_hit", 64'(bus.pending_hit), 64'(pend));
        chk("stall", 64'(bus.stall), 64'(m_stall));
        if (reset) begin
            mq.delete();
            m_stall = 0;
        end else begin
            conflict = conflict && !xz(me.r, me.f);
            direct   = bus.main_write && !xz(me.r, me.f) && !conflict;
            deq      = !direct && mq.size() > 0;
            byp_ok   = 0;
`ifdef WB_BYPASS_EN
            byp_ok   = !bus.main_write && mq.size() == 0;
`endif
            mbyp = byp_ok && bus.multiplier_done && !xz(mu.r, mu.f);
            dbyp = byp_ok && bus.divider_done && !xz(dv.r, dv.f) && !mbyp;
            if (direct) exp_q.push_back(me);
            else if (deq) exp_q.push_back(mq.pop_front());
            else if (mbyp) exp_q.push_back(mu);
            else if (dbyp) exp_q.push_back(dv);
            if (bus.main_write && conflict) mq.push_back(me);
            mneed = bus.multiplier_done && !xz(mu.r, mu.f) && !mbyp;
            mack  = bus.multiplier_done && (!mneed || mq.size() < DEPTH);
            if (mack && mneed) mq.push_back(mu);
            dneed = bus.divider_done && !xz(dv.r, dv.f) && !dbyp;
            dack  = bus.divider_done && (!dneed || mq.size() < DEPTH);
            if (dack && dneed) mq.push_back(dv);
            m_stall = mq.size() >= DEPTH - 1;
        end
        chk("mult_ack", 64'(bus.mult_ack), 64'(mack));
        chk("div_ack", 64'(bus.div_ack), 64'(dack));
        exp_mack = mack;
        exp_dack = dack;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
        model_cycle();
        @(posedge clk);
        #1;
        if (exp_mack) bus.multiplier_done = 1'b0;
        if (exp_dack) bus.divider_done = 1'b0;
    endtask

    task automatic set_main(input logic w, input logic [4:0] r, input logic [WORD-1:0] d);
        bus.main_write = w;
        bus.main_reg   = r;
        bus.main_fp    = 1'b0;
        bus.main_data  = d;
    endtask

    task automatic give_mult(input logic [4:0] r, input logic f, input logic [WORD-1:0] d);
        int n = 0;
        while (bus.multiplier_done && n < 200) begin tick(); n++; end
        if (n >= 200) chk("give_mult wait", 64'(n), 64'(0));
        bus.mult_reg = r; bus.mult_fp = f; bus.mult_data = d; bus.multiplier_done = 1'b1;
    endtask

    task automatic give_div(input logic [4:0] r, input logic f, input logic [WORD-1:0] d);
        int n = 0;
        while (bus.divider_done && n < 200) begin tick(); n++; end
        if (n >= 200) chk("give_div wait", 64'(n), 64'(0));
        bus.div_reg = r; bus.div_fp = f; bus.div_data = d; bus.divider_done = 1'b1;
    endtask

    // Monitor: every register-file write must be the next expected one.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.wb_write === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected write: reg %0d fp %0d data %0h", bus.wb_reg, bus.wb_fp, bus.wb_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wb_reg", 64'(bus.wb_reg), 64'(mon_e.r));
                    chk("wb_fp", 64'(bus.wb_fp), 64'(mon_e.f));
                    chk("wb_data", bus.wb_data, mon_e.d);
                end
                if (!bus.wb_fp) rf_int[bus.wb_reg] = bus.wb_data;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not complete");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        m_stall = 0;
        reset = 1'b1;
        set_main(1'b0, 5'd0, '0);
        bus.multiplier_done = 1'b0; bus.mult_reg = '0; bus.mult_fp = 1'b0; bus.mult_data = '0;
        bus.divider_done = 1'b0; bus.div_reg = '0; bus.div_fp = 1'b0; bus.div_data = '0;
        bus.read_reg1 = '0; bus.read_reg2 = '0; bus.read_fp = 1'b0;
        @(posedge clk);
        #1;
        repeat (2) tick();
        chk("reset wb_write", 64'(bus.wb_write), 64'(0));
        chk("reset wb_reg", 64'(bus.wb_reg), 64'(0));
        chk("reset wb_fp", 64'(bus.wb_fp), 64'(0));
        chk("reset wb_data", bus.wb_data, 64'(0));
        chk("reset stall", 64'(bus.stall), 64'(0));
        reset = 1'b0;

        // Main path, latency 1.
        set_main(1'b1, 5'd5, 64'h1234);
        tick();
        chk("main wb_write", 64'(bus.wb_write), 64'(1));
        chk("main wb_reg", 64'(bus.wb_reg), 64'(5));
        chk("main wb_data", bus.wb_data, 64'h1234);
        set_main(1'b0, 5'd0, '0);
        repeat (2) tick();

        // Multiplier result deferred behind a busy main path.
        bus.read_reg1 = 5'd7;
        set_main(1'b1, 5'd3, 64'h33);
        give_mult(5'd7, 1'b0, 64'hAA);
        repeat (3) tick();
        set_main(1'b0, 5'd0, '0);
        repeat (3) tick();
        chk("mult pending cleared", 64'(bus.pending_hit), 64'(0));

        // Simultaneous multiplier and divider with an idle port.
        give_mult(5'd10, 1'b0, 64'h1010);
        give_div(5'd11, 1'b1, 64'h1111);
        repeat (4) tick();

        // Fill the FIFO while main is busy; later results must wait.
        set_main(1'b1, 5'd1, 64'h1);
        give_mult(5'd12, 1'b0, 64'h12); tick();
        give_div(5'd13, 1'b0, 64'h13);  tick();
        give_mult(5'd14, 1'b1, 64'h14); tick();
        give_div(5'd15, 1'b0, 64'h15);  tick();
        give_mult(5'd16, 1'b0, 64'h16); tick();
        give_div(5'd17, 1'b0, 64'h17);  tick(); tick();
        chk("stall when full", 64'(bus.stall), 64'(1));
        set_main(1'b0, 5'd0, '0);
        repeat (12) tick();

        // Queued divider write to x9 must precede a later main write to x9.
        give_div(5'd9, 1'b0, 64'hD1);
        tick();
        set_main(1'b1, 5'd9, 64'h99);
        tick();
        set_main(1'b0, 5'd0, '0);
        repeat (4) tick();
        chk("x9 final value", rf_int[9], 64'h99);

        // Reset with three entries queued discards them.
        bus.read_reg1 = 5'd20; bus.read_reg2 = 5'd21;
        set_main(1'b1, 5'd2, 64'h2);
        give_mult(5'd20, 1'b0, 64'h20); tick();
        give_div(5'd21, 1'b0, 64'h21);  tick();
        give_mult(5'd22, 1'b0, 64'h22); tick();
        reset = 1'b1;
        set_main(1'b0, 5'd0, '0);
        tick();
        reset = 1'b0;
        chk("post-reset wb_write", 64'(bus.wb_write), 64'(0));
        chk("post-reset stall", 64'(bus.stall), 64'(0));
        chk("post-reset pending", 64'(bus.pending_hit), 64'(0));
        repeat (3) tick();

        // Randomized traffic with alternating main-path load.
        for (int c = 0; c < 3000; c++) begin
            int dens;
            dens = ((c / 150) % 2) != 0 ? 9 : 3;
            reset = ($urandom_range(0, 299) == 0);
            bus.main_write = ($urandom_range(0, 9) < dens);
            bus.main_reg   = rnd_reg();
            bus.main_fp    = ($urandom_range(0, 3) == 0);
            bus.main_data  = {$urandom(), $urandom()};
            if (!bus.multiplier_done && $urandom_range(0, 2) == 0)
                give_mult(rnd_reg(), ($urandom_range(0, 3) == 0), {$urandom(), $urandom()});
            if (!bus.divider_done && $urandom_range(0, 2) == 0)
                give_div(rnd_reg(), ($urandom_range(0, 3) == 0), {$urandom(), $urandom()});
            bus.read_reg1 = rnd_reg();
            bus.read_reg2 = rnd_reg();
            bus.read_fp   = ($urandom_range(0, 3) == 0);
            tick();
        end

        reset = 1'b0;
        set_main(1'b0, 5'd0, '0);
        repeat (20) tick();
        chk("drain expected writes", 64'(exp_q.size()), 64'(0));
        chk("drain done inputs", 64'({bus.multiplier_done, bus.divider_done}), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
